// File: rtl/answer_entry_check_if.sv
// Bus between the answer-entry checker and its driver: start/expected snapshot,
// switch data with the Go button, and the entry/result status.
interface answer_entry_check_if #(
   parameter int WIDTH     = 8,
   parameter int N_ENTRIES = 6
);
   logic                         start;
   logic [N_ENTRIES*WIDTH-1:0]   exp_flat;
   logic [WIDTH-1:0]             data_in;
   logic                         Go;
   logic [2:0]                   entry_idx;
   logic                         awaiting;
   logic                         retry_pulse;
   logic [N_ENTRIES-1:0]         mismatch_mask;
   logic [1:0]                   tries_used;
   logic                         correct;
   logic                         wrong;

   modport master (
      output start, exp_flat, data_in, Go,
      input  entry_idx, awaiting, retry_pulse, mismatch_mask, tries_used, correct, wrong
   );

   modport slave (
      input  start, exp_flat, data_in, Go,
      output entry_idx, awaiting, retry_pulse, mismatch_mask, tries_used, correct, wrong
   );
endinterface

// File: rtl/answer_entry_check.sv
// Snapshots the reduced matrix entries, collects one keyed answer per Go press and
// reports correct/wrong after a bounded number of attempts.
module answer_entry_check #(
   parameter int WIDTH     = 8,
   parameter int N_ENTRIES = 6,
   parameter int MAX_TRIES = 3
) (
   input  logic                 Clock,
   input  logic                 Reset,
   answer_entry_check_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_GO = 2'd1,
      COMPARE = 2'd2,
      RESULT  = 2'd3
   } state_t;

   localparam logic [2:0] LAST_IDX  = 3'(N_ENTRIES - 1);
   localparam logic [1:0] TRY_LIMIT = 2'(MAX_TRIES);

   state_t               state_q, state_d;
   logic                 go_q;
   logic                 go_rise;
   logic [2:0]           idx_q, idx_d;
   logic [N_ENTRIES-1:0] mask_q, mask_d;
   logic [1:0]           tries_q, tries_d;
   logic [1:0]           tries_inc;
   logic                 correct_q, correct_d;
   logic                 wrong_q, wrong_d;
   logic                 retry_q, retry_d;
   logic [WIDTH-1:0]     exp_q  [N_ENTRIES];
   logic [WIDTH-1:0]     exp_d  [N_ENTRIES];
   logic [WIDTH-1:0]     exp_in [N_ENTRIES];
   logic [WIDTH-1:0]     exp_sel;

   generate
      for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_unpack
         assign exp_in[gi] = bus.exp_flat[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // go_q follows Go in every state, so a button already held on entry never counts as a press.
   assign go_rise   = bus.Go & ~go_q;
   assign exp_sel   = exp_q[idx_q];
   assign tries_inc = tries_q + 2'd1;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mask_d    = mask_q;
      tries_d   = tries_q;
      correct_d = correct_q;
      wrong_d   = wrong_q;
      retry_d   = 1'b0;
      exp_d     = exp_q;

      case (state_q)
         IDLE, RESULT: begin
            if (bus.start) begin
               exp_d     = exp_in;
               idx_d     = 3'd0;
               mask_d    = '0;
               tries_d   = 2'd0;
               correct_d = 1'b0;
               wrong_d   = 1'b0;
               state_d   = WAIT_GO;
            end
         end

         WAIT_GO: begin
            if (go_rise) begin
               // The first capture of a retry wipes the previous attempt's mask.
               if (idx_q == 3'd0) begin
                  mask_d = '0;
               end
               mask_d[idx_q] = (bus.data_in != exp_sel);
               if (idx_q == LAST_IDX) begin
                  state_d = COMPARE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         COMPARE: begin
            tries_d = tries_inc;
            if (mask_q == '0) begin
               correct_d = 1'b1;
               state_d   = RESULT;
            end else if (tries_inc == TRY_LIMIT) begin
               wrong_d = 1'b1;
               state_d = RESULT;
            end else begin
               retry_d = 1'b1;
               idx_d   = 3'd0;
               state_d = WAIT_GO;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= IDLE;
         go_q      <= 1'b0;
         idx_q     <= 3'd0;
         mask_q    <= '0;
         tries_q   <= 2'd0;
         correct_q <= 1'b0;
         wrong_q   <= 1'b0;
         retry_q   <= 1'b0;
         for (int i = 0; i < N_ENTRIES; i++) begin
            exp_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         go_q      <= bus.Go;
         idx_q     <= idx_d;
         mask_q    <= mask_d;
         tries_q   <= tries_d;
         correct_q <= correct_d;
         wrong_q   <= wrong_d;
         retry_q   <= retry_d;
         exp_q     <= exp_d;
      end
   end

   assign bus.entry_idx     = idx_q;
   assign bus.awaiting      = (state_q == WAIT_GO);
   assign bus.retry_pulse   = retry_q;
   assign bus.mismatch_mask = mask_q;
   assign bus.tries_used    = tries_q;
   assign bus.correct       = correct_q;
   assign bus.wrong         = wrong_q;
endmodule

// File: tb/tb_answer_entry_check.sv
// Self-checking bench for answer_entry_check: directed game scenarios followed by
// randomized sessions, all checked against a behavioural session model.
module tb_answer_entry_check;
   localparam int WIDTH     = 8;
   localparam int N         = 6;
   localparam int MAX_TRIES = 3;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   answer_entry_check_if #(.WIDTH(WIDTH), .N_ENTRIES(N)) bus ();

   answer_entry_check #(.WIDTH(WIDTH), .N_ENTRIES(N), .MAX_TRIES(MAX_TRIES)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   // Session model: snapshot, progress through the answer, and outcome.
   logic [N*WIDTH-1:0] m_expf;
   int                 m_idx;
   int                 m_tries;
   logic [N-1:0]       m_mask;
   bit                 m_correct, m_wrong, m_retry, m_awaiting;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_all(input string tag);
      check_val({tag, "/idx"},      64'(bus.entry_idx),     64'(m_idx));
      check_val({tag, "/await"},    64'(bus.awaiting),      64'(m_awaiting));
      check_val({tag, "/retry"},    64'(bus.retry_pulse),   64'(m_retry));
      check_val({tag, "/mask"},     64'(bus.mismatch_mask), 64'(m_mask));
      check_val({tag, "/tries"},    64'(bus.tries_used),    64'(m_tries));
      check_val({tag, "/correct"},  64'(bus.correct),       64'(m_correct));
      check_val({tag, "/wrong"},    64'(bus.wrong),         64'(m_wrong));
      check_val({tag, "/excl"},     64'(bus.correct & bus.wrong), 64'(0));
   endtask

   task automatic model_clear();
      m_expf = '0; m_idx = 0; m_tries = 0; m_mask = '0;
      m_correct = 0; m_wrong = 0; m_retry = 0; m_awaiting = 0;
   endtask

   task automatic do_start(input logic [N*WIDTH-1:0] flat);
      bus.exp_flat = flat;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      m_expf = flat; m_idx = 0; m_mask = '0; m_tries = 0;
      m_correct = 0; m_wrong = 0; m_retry = 0; m_awaiting = 1;
      check_all("start");
   endtask

   // One Go press held for 'hold' cycles (hold > 1 only used before the last entry).
   task automatic press(input logic [WIDTH-1:0] d, input int hold);
      bus.data_in = d;
      bus.Go      = 1'b1;
      tick();
      if (m_idx == 0) m_mask = '0;
      m_mask[m_idx] = (d != m_expf[m_idx*WIDTH +: WIDTH]);
      m_retry = 0;
      if (m_idx == N - 1) begin
         m_awaiting = 0;
         check_all("cap_last");
         bus.Go = 1'b0;
         tick();
         m_tries++;
         if (m_mask == '0) begin
            m_correct = 1;
         end else if (m_tries == MAX_TRIES) begin
            m_wrong = 1;
         end else begin
            m_retry = 1; m_idx = 0; m_awaiting = 1;
         end
         check_all("outcome");
         if (m_retry) begin
            tick();
            m_retry = 0;
            check_all("retry_end");
         end
      end else begin
         m_idx++;
         check_all("cap");
         for (int k = 1; k < hold; k++) begin
            tick();
            check_all("hold");
         end
         bus.Go      = 1'b0;
         bus.data_in = WIDTH'($urandom);
         tick();
         check_all("rel");
      end
   endtask

   task automatic attempt(input logic [N*WIDTH-1:0] ans, input bit gaps);
      for (int i = m_idx; i < N; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               tick();
               check_all("gap");
            end
         end
         press(ans[i*WIDTH +: WIDTH], 1);
      end
   endtask

   task automatic press_ignored(input logic [WIDTH-1:0] d);
      bus.data_in = d;
      bus.Go      = 1'b1;
      tick();
      check_all("ign_hi");
      bus.Go = 1'b0;
      tick();
      check_all("ign_lo");
   endtask

   logic [N*WIDTH-1:0] exp_a;
   logic [N*WIDTH-1:0] ans;
   logic [N*WIDTH-1:0] rexp;

   initial begin
      bus.start = 1'b0; bus.Go = 1'b0; bus.data_in = '0; bus.exp_flat = '0;
      exp_a = {8'd2, 8'd1, 8'd0, 8'd3, 8'd0, 8'd1};

      // Reset for two cycles
      tick(); tick();
      model_clear();
      check_all("reset");
      Reset = 1'b0;
      tick();
      check_all("idle");

      // Straight correct pass
      do_start(exp_a);
      attempt(exp_a, 0);

      // One wrong entry then a correct pass
      do_start(exp_a);
      ans = exp_a; ans[3*WIDTH +: WIDTH] = 8'd5;
      attempt(ans, 0);
      check_val("retry_mask", 64'(bus.mismatch_mask), 64'(6'b001000));
      attempt(exp_a, 0);
      check_val("second_pass_tries", 64'(bus.tries_used), 64'(2));

      // Three wrong passes, then Go presses in RESULT do nothing
      do_start(exp_a);
      ans = '1;
      for (int t = 0; t < MAX_TRIES; t++) attempt(ans, 0);
      check_val("lockout_wrong", 64'(bus.wrong), 64'(1));
      press_ignored(8'd1);
      press_ignored(8'd0);

      // Go held 20 cycles gives one capture
      do_start(exp_a);
      press(exp_a[0 +: WIDTH], 20);
      attempt(exp_a, 0);

      // Go already high when start arrives
      bus.Go = 1'b1;
      bus.data_in = exp_a[0 +: WIDTH];
      do_start(exp_a);
      repeat (3) begin
         tick();
         check_all("go_pre_held");
      end
      bus.Go = 1'b0;
      tick();
      check_all("go_pre_rel");
      attempt(exp_a, 0);

      // exp_flat changed mid-entry is ignored
      do_start(exp_a);
      press(exp_a[0 +: WIDTH], 1);
      press(exp_a[WIDTH +: WIDTH], 1);
      bus.exp_flat = ~exp_a;
      attempt(exp_a, 0);

      // Reset mid-entry at index 4, then a fresh session
      do_start(exp_a);
      for (int i = 0; i < 4; i++) press(exp_a[i*WIDTH +: WIDTH], 1);
      check_val("pre_reset_idx", 64'(bus.entry_idx), 64'(4));
      Reset = 1'b1;
      tick();
      model_clear();
      check_all("reset_mid");
      Reset = 1'b0;
      tick();
      check_all("after_reset");
      do_start(exp_a);
      attempt(exp_a, 0);

      // Randomized sessions
      for (int s = 0; s < 25; s++) begin
         for (int i = 0; i < N; i++) begin
            rexp[i*WIDTH +: WIDTH] = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 3))
                                                                 : WIDTH'($urandom);
         end
         do_start(rexp);
         while (!(m_correct || m_wrong)) begin
            ans = rexp;
            if ($urandom_range(0, 2) != 0) begin
               repeat ($urandom_range(1, 3)) begin
                  int k;
                  k = $urandom_range(0, N - 1);
                  ans[k*WIDTH +: WIDTH] = ans[k*WIDTH +: WIDTH] ^ WIDTH'($urandom_range(1, 255));
               end
            end
            attempt(ans, 1);
         end
         if ($urandom_range(0, 1) == 0) press_ignored(WIDTH'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
